// File: rtl/des_pkg.sv
// Shared DES datapath types and helpers.
// Nibble expansion with wrap-around neighbour bits.
package des_pkg;

   localparam int DEF_NIB_W   = 4;
   localparam int DEF_NIB_CNT = 8;
   localparam int EXP_MAX     = 128;

   // Result sits in the low (nib_w+2)*nib_cnt bits, chunk 0 at the top.
   function automatic logic [EXP_MAX-1:0] expand_nibbles(
      input logic [EXP_MAX-1:0] din,
      input int                 nib_w,
      input int                 nib_cnt
   );
      logic [EXP_MAX-1:0] res;
      int in_w;
      int out_w;
      int hi;
      int lo;
      int top;
      res   = '0;
      in_w  = nib_w * nib_cnt;
      out_w = (nib_w + 2) * nib_cnt;
      for (int k = 0; k < nib_cnt; k++) begin
         hi  = in_w - 1 - k * nib_w;
         lo  = hi - nib_w + 1;
         top = out_w - 1 - k * (nib_w + 2);
         res[top] = din[(hi + 1) % in_w];
         for (int j = 0; j < nib_w; j++)
            res[top-1-j] = din[hi-j];
         res[top-nib_w-1] = din[(lo - 1 + in_w) % in_w];
      end
      return res;
   endfunction

endpackage

// File: rtl/expansion_stream_if.sv
// Valid/ready bundle for the expansion stage.
// slave = the stage itself, master = source and consumer side.
interface expansion_stream_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 48,
   parameter int CNT_W = 2
);

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [OUT_W-1:0] in_key;
   logic             in_xor_en;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [CNT_W-1:0] count;

   modport slave (
      input  in_valid, in_data, in_key, in_xor_en, out_ready,
      output in_ready, out_valid, out_data, count
   );

   modport master (
      output in_valid, in_data, in_key, in_xor_en, out_ready,
      input  in_ready, out_valid, out_data, count
   );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; occupancy decides full/empty.
// Read is combinational from the registered array.
module sync_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             flush,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             push;
   logic             pop;

   assign push_ready = (count != CNT_W'(DEPTH)) && !flush;
   assign pop_valid  = (count != '0);
   assign pop_data   = mem[rd_ptr];
   assign push       = push_valid && push_ready;
   assign pop        = pop_valid && pop_ready && !flush;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/expansion_stream.sv
// Streaming E-expansion with optional subkey XOR,
// buffered ahead of the S-box stage.
module expansion_stream
   import des_pkg::*;
#(
   parameter int NIB_W   = DEF_NIB_W,
   parameter int NIB_CNT = DEF_NIB_CNT,
   parameter int DEPTH   = 2,
   localparam int IN_W  = NIB_W * NIB_CNT,
   localparam int OUT_W = (NIB_W + 2) * NIB_CNT,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input logic                clk,
   input logic                n_rst,
   input logic                flush,
   expansion_stream_if.slave  bus
);

   logic [OUT_W-1:0] expanded;
   logic [OUT_W-1:0] key_mask;
   logic [OUT_W-1:0] word;

   assign expanded = OUT_W'(expand_nibbles(EXP_MAX'(bus.in_data),
                                           NIB_W, NIB_CNT));
   assign key_mask = bus.in_xor_en ? bus.in_key : '0;
   assign word     = expanded ^ key_mask;

   sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .n_rst      (n_rst),
      .flush      (flush),
      .push_valid (bus.in_valid),
      .push_ready (bus.in_ready),
      .push_data  (word),
      .pop_valid  (bus.out_valid),
      .pop_ready  (bus.out_ready),
      .pop_data   (bus.out_data),
      .count      (bus.count)
   );

endmodule

// File: tb/tb_expansion_stream.sv
// Directed bench for expansion_stream: DES vectors, backpressure,
// concurrent push/pop, flush, async reset, and a 6x4 geometry.
module tb_expansion_stream;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic flush_a = 1'b0;
   logic flush_b = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   expansion_stream_if #(.IN_W(32), .OUT_W(48), .CNT_W(2)) bus_a ();
   expansion_stream_if #(.IN_W(24), .OUT_W(32), .CNT_W(2)) bus_b ();

   expansion_stream #(.NIB_W(4), .NIB_CNT(8), .DEPTH(2)) dut_a (
      .clk   (clk),
      .n_rst (n_rst),
      .flush (flush_a),
      .bus   (bus_a.slave)
   );

   expansion_stream #(.NIB_W(6), .NIB_CNT(4), .DEPTH(2)) dut_b (
      .clk   (clk),
      .n_rst (n_rst),
      .flush (flush_b),
      .bus   (bus_b.slave)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Bit-wise reference: output bit p of chunk k reads input bit
   // (k*nw + p - 1) mod in_w, counted from the MSB.
   function automatic logic [63:0] model(input logic [63:0] d,
                                         input int nw, input int nc);
      logic [63:0] r;
      int in_w;
      int cw;
      int src;
      r    = '0;
      in_w = nw * nc;
      cw   = nw + 2;
      for (int o = 0; o < cw * nc; o++) begin
         src = (((o / cw) * nw + (o % cw) - 1) + in_w) % in_w;
         r[cw*nc-1-o] = d[in_w-1-src];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [31:0] d, input logic [47:0] k,
                         input logic x);
      bus_a.in_data   = d;
      bus_a.in_key    = k;
      bus_a.in_xor_en = x;
      bus_a.in_valid  = 1'b1;
      tick();
      bus_a.in_valid  = 1'b0;
   endtask

   task automatic pop_a();
      bus_a.out_ready = 1'b1;
      tick();
      bus_a.out_ready = 1'b0;
   endtask

   logic [47:0] q[$];
   logic [31:0] rd;
   logic [23:0] rb;

   initial begin
      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_key = '0;
      bus_a.in_xor_en = 1'b0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_key = '0;
      bus_b.in_xor_en = 1'b0; bus_b.out_ready = 1'b0;

      // reset state
      #12;
      check("rst_count", 64'(bus_a.count), 64'd0);
      check("rst_oval", 64'(bus_a.out_valid), 64'd0);
      check("rst_irdy", 64'(bus_a.in_ready), 64'd1);
      check("rst_odata", 64'(bus_a.out_data), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      tick();

      // DES E-expansion vectors
      send_a(32'hF0AAF0AA, 48'h0, 1'b0);
      check("des_oval", 64'(bus_a.out_valid), 64'd1);
      check("des_data", 64'(bus_a.out_data), 64'h7A15557A1555);
      check("des_cnt", 64'(bus_a.count), 64'd1);
      pop_a();
      check("des_pop_cnt", 64'(bus_a.count), 64'd0);
      check("des_pop_oval", 64'(bus_a.out_valid), 64'd0);

      send_a(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1);
      check("keyed", 64'(bus_a.out_data), 64'h6117BA866527);
      pop_a();
      send_a(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0);
      check("key_ignored", 64'(bus_a.out_data), 64'h7A15557A1555);
      pop_a();
      send_a(32'h00000001, 48'h0, 1'b0);
      check("wrap_lsb", 64'(bus_a.out_data), 64'h800000000002);
      pop_a();
      send_a(32'h80000000, 48'h0, 1'b0);
      check("wrap_msb", 64'(bus_a.out_data), 64'h400000000001);
      pop_a();

      // backpressure: third beat must wait for room
      bus_a.in_xor_en = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.in_data   = 32'hF0AAF0AA;
      tick();
      bus_a.in_data   = 32'h00000001;
      tick();
      bus_a.in_data   = 32'h80000000;
      check("bp_full_cnt", 64'(bus_a.count), 64'd2);
      check("bp_irdy_low", 64'(bus_a.in_ready), 64'd0);
      tick();
      check("bp_hold_cnt", 64'(bus_a.count), 64'd2);
      check("bp_head", 64'(bus_a.out_data), 64'h7A15557A1555);
      bus_a.out_ready = 1'b1;
      tick();
      check("bp_pop_only", 64'(bus_a.count), 64'd1);
      check("bp_irdy_back", 64'(bus_a.in_ready), 64'd1);
      check("bp_second", 64'(bus_a.out_data), 64'h800000000002);
      tick();
      bus_a.in_valid = 1'b0;
      check("bp_cnt_same", 64'(bus_a.count), 64'd1);
      check("bp_third", 64'(bus_a.out_data), 64'h400000000001);
      tick();
      bus_a.out_ready = 1'b0;
      check("bp_empty", 64'(bus_a.count), 64'd0);

      // concurrent push and pop at count 1
      rd = $urandom;
      send_a(rd, 48'h0, 1'b0);
      q.push_back(48'(model(64'(rd), 4, 8)));
      bus_a.in_valid  = 1'b1;
      bus_a.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rd = $urandom;
         bus_a.in_data = rd;
         check("cc_head", 64'(bus_a.out_data), 64'(q[0]));
         void'(q.pop_front());
         q.push_back(48'(model(64'(rd), 4, 8)));
         tick();
         check("cc_cnt", 64'(bus_a.count), 64'd1);
      end
      bus_a.in_valid = 1'b0;
      check("cc_last", 64'(bus_a.out_data), 64'(q[0]));
      tick();
      bus_a.out_ready = 1'b0;
      check("cc_drain", 64'(bus_a.count), 64'd0);

      // flush discards contents and any push in the same cycle
      send_a(32'h12345678, 48'h0, 1'b0);
      send_a(32'h9ABCDEF0, 48'h0, 1'b0);
      check("fl_full", 64'(bus_a.count), 64'd2);
      pop_a();
      flush_a = 1'b1;
      bus_a.in_valid = 1'b1;
      #1;
      check("fl_irdy", 64'(bus_a.in_ready), 64'd0);
      tick();
      flush_a = 1'b0;
      bus_a.in_valid = 1'b0;
      check("fl_cnt", 64'(bus_a.count), 64'd0);
      check("fl_oval", 64'(bus_a.out_valid), 64'd0);

      // asynchronous reset between edges
      send_a(32'hDEADBEEF, 48'h0, 1'b0);
      send_a(32'h0BADF00D, 48'h0, 1'b0);
      #2;
      n_rst = 1'b0;
      #1;
      check("ar_cnt", 64'(bus_a.count), 64'd0);
      check("ar_oval", 64'(bus_a.out_valid), 64'd0);
      check("ar_irdy", 64'(bus_a.in_ready), 64'd1);
      check("ar_odata", 64'(bus_a.out_data), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      tick();

      // 6-bit nibbles, 4 of them
      bus_b.in_data  = 24'h000001;
      bus_b.in_valid = 1'b1;
      tick();
      bus_b.in_valid = 1'b0;
      check("b_wrap", 64'(bus_b.out_data), 64'h80000002);
      bus_b.out_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         rb = 24'($urandom);
         bus_b.in_data   = rb;
         bus_b.in_key    = 32'($urandom);
         bus_b.in_xor_en = i[0];
         bus_b.in_valid  = 1'b1;
         bus_b.out_ready = 1'b0;
         tick();
         bus_b.in_valid  = 1'b0;
         check("b_model", 64'(bus_b.out_data),
               model(64'(rb), 6, 4) ^ (i[0] ? 64'(bus_b.in_key) : 64'd0));
         bus_b.out_ready = 1'b1;
         tick();
      end
      check("b_empty", 64'(bus_b.count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/expansion_stream.md
Name: expansion_stream

Overview:
- Parametrised, streaming successor to the fixed 32→48 DES E-expansion.
- Expands an IN_W-bit half-block, split into NIB_CNT nibbles of NIB_W bits, into NIB_CNT chunks of NIB_W+2 bits using wrap-around neighbour bits.
- Optionally XORs the result with a per-beat subkey.
- Buffers results in a small output FIFO with valid/ready handshakes on both sides.
- Sits between the round-register datapath and the S-box stage of the Feistel round engine.

Parameters:
- NIB_W, 4, bits per nibble (≥2).
- NIB_CNT, 8, number of nibbles.
- DEPTH, 2, output FIFO entries (power of two, ≥2).
- Derived, not overridable: IN_W = NIB_W*NIB_CNT; OUT_W = (NIB_W+2)*NIB_CNT; CNT_W = $clog2(DEPTH)+1.

Ports:
- clk, input, 1, system clock, rising edge.
- n_rst, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous clear of FIFO contents.
- in_valid, input, 1, input beat present.
- in_ready, output, 1, block can accept a beat.
- in_data, input, IN_W, half-block to expand.
- in_key, input, OUT_W, subkey for this beat.
- in_xor_en, input, 1, 1 = XOR with in_key, 0 = expansion only.
- out_valid, output, 1, FIFO head valid.
- out_ready, input, 1, consumer accepts head.
- out_data, output, OUT_W, expanded (and optionally keyed) beat.
- count, output, CNT_W, current FIFO occupancy.

Behaviour:
- Reset: asynchronous on n_rst low. FIFO empty, rd/wr pointers 0, count=0, out_valid=0, in_ready=1, out_data=0.
- Expansion is combinational on in_data. Nibble k (k=0 is the MSB nibble) spans bits [hi:lo], hi = IN_W-1-k*NIB_W, lo = hi-NIB_W+1.
  - chunk k = {in_data[(hi+1) mod IN_W], in_data[hi:lo], in_data[(lo-1+IN_W) mod IN_W]}.
  - Chunks are concatenated with chunk 0 at the MSBs.
  - Defaults reproduce standard DES E exactly.
- Keying: word = expand(in_data) ^ (in_xor_en ? in_key : 0). in_key is ignored when in_xor_en=0.
- Push: in_valid && in_ready. The word is written into the FIFO at the next rising edge.
  - Latency: accepted beat is visible on out_data with out_valid=1 in the cycle after acceptance, if the FIFO was empty.
- Pop: out_valid && out_ready. Head advances at the next edge.
- in_ready = (count != DEPTH) && !flush. Purely combinational from registered count; no dependency on out_ready.
  - When full, a pop does not enable a push in the same cycle.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- out_valid = (count != 0). out_data = mem[rd_ptr], combinational read of a registered array.
  - out_data holds its value while out_valid && !out_ready.
  - When empty, out_data is don't-care; the bench must not check it.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are decided by count, not pointer compare.
- flush=1: at the next edge count, rd_ptr and wr_ptr become 0, and any push or pop in that cycle is discarded. in_ready=0 during flush. out_valid falls the cycle after flush.
- Reset mid-stream: all buffered beats are lost. The block returns to the reset state immediately, independent of clk.
- No state machine beyond the FIFO. Fill states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), all derived from count.

Decomposition:
- Package des_pkg holds:
  - Default NIB_W/NIB_CNT constants.
  - Pure function expand_nibbles(in, NIB_W, NIB_CNT) implementing the wrap rule, shared with the future P-box and S-box stages.
- One sub-module: sync_fifo (parametrised WIDTH, DEPTH, with flush), instantiated with WIDTH=OUT_W.
- Expansion and XOR stay inline in expansion_stream.

Test Plan:
- DES vector: in_data=0xF0AAF0AA, in_xor_en=0 → out_data=0x7A15557A1555 one cycle after acceptance.
- Keyed: same in_data, in_key=0x1B02EFFC7072, in_xor_en=1 → out_data=0x6117BA866527.
- Wrap bits: in_data=0x00000001, xor off → 0x800000000002. in_data=0x80000000 → 0x400000000001.
- Backpressure: out_ready=0, push 3 beats (DEPTH=2) → in_ready=0 after 2 accepts, count=2, third beat held by source. Raise out_ready → beats emerge in order, none lost or duplicated.
- Concurrent: with count=1, push and pop in the same cycle for 20 cycles with random data → count stays 1, output order matches the reference-model queue.
- Flush and reset: fill to 2, pulse flush → count=0 and out_valid=0 next cycle. Refill, drop n_rst between clock edges → outputs reach reset values without waiting for a clk edge. Also rerun with NIB_W=6, NIB_CNT=4 against the model.
